// File: rtl/pe_host_seq.sv
// Host-side sequencer for a PE subarray: loads weight/input buffers, kicks the PE,
// drains its output buffer through a 4-entry result FIFO. Optional watchdog: PE_HOST_SEQ_TIMEOUT_EN.
module pe_host_seq #(
  parameter int SUBARRAY_ROWS  = 32,
  parameter int SUBARRAY_COLS  = 8,
  parameter int INPUT_WIDTH    = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int BUF_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int WBW = SUBARRAY_ROWS * SUBARRAY_COLS * WEIGHT_WIDTH,
  localparam int IBW = SUBARRAY_COLS * INPUT_WIDTH,
  localparam int OBW = SUBARRAY_ROWS * OUTPUT_WIDTH,
  localparam int AW  = $clog2(BUF_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [AW:0]    cmd_len,
  input  logic           cmd_clear,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [WBW-1:0] w_data,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [IBW-1:0] i_data,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [OBW-1:0] o_data,
  output logic           o_last,
  output logic [AW-1:0]  wbuf_wr_addr,
  output logic [WBW-1:0] wbuf_wr_data,
  output logic           wbuf_wr_en,
  output logic [AW-1:0]  ibuf_wr_addr,
  output logic [IBW-1:0] ibuf_wr_data,
  output logic           ibuf_wr_en,
  output logic [AW-1:0]  obuf_rd_addr,
  output logic           obuf_rd_en,
  input  logic [OBW-1:0] obuf_rd_data,
  output logic           pe_start,
  output logic           pe_clear_acc,
  input  logic           pe_busy,
  input  logic           pe_done,
  output logic           seq_busy,
  output logic           seq_done,
  output logic           seq_err
);

  localparam int CW     = AW + 1;
  localparam int FIFO_D = 4;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     n_q;
  logic              clear_q;
  logic [CW-1:0]     w_cnt_q, i_cnt_q, rd_cnt_q, pop_cnt_q;
  logic              rd_vld_p0_q, rd_vld_p1_q;
  logic [OBW-1:0]    fifo_q [FIFO_D];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        fifo_cnt_q;

  logic              cmd_fire, w_fire, i_fire;
  logic              rd_issue, push, pop, last_pop;
  logic [CW-1:0]     n_cmd;
  logic [2:0]        occupancy;
  logic              timeout_hit;

  // pe_busy is informational only; sequencing keys off pe_done
  logic              unused_pe_busy;
  assign unused_pe_busy = pe_busy;

  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign n_cmd     = ((cmd_len == '0) || (cmd_len > CW'(BUF_DEPTH))) ? CW'(BUF_DEPTH) : cmd_len;

  assign w_ready = (state_q == LOAD) && (w_cnt_q < n_q);
  assign i_ready = (state_q == LOAD) && (i_cnt_q < n_q);
  assign w_fire  = w_valid & w_ready;
  assign i_fire  = i_valid & i_ready;

  assign wbuf_wr_en   = w_fire;
  assign wbuf_wr_addr = w_fire ? w_cnt_q[AW-1:0] : '0;
  assign wbuf_wr_data = w_fire ? w_data : '0;
  assign ibuf_wr_en   = i_fire;
  assign ibuf_wr_addr = i_fire ? i_cnt_q[AW-1:0] : '0;
  assign ibuf_wr_data = i_fire ? i_data : '0;

  // Every issued read reserves a FIFO slot, so the FIFO can never overflow
  assign occupancy = {2'b00, rd_vld_p0_q} + {2'b00, rd_vld_p1_q} + fifo_cnt_q;
  assign rd_issue  = (state_q == DRAIN) && (rd_cnt_q < n_q) && (occupancy < 3'd4);
  assign push      = rd_vld_p1_q;

  assign obuf_rd_en   = rd_issue;
  assign obuf_rd_addr = rd_issue ? rd_cnt_q[AW-1:0] : '0;

  assign o_valid  = (fifo_cnt_q != 3'd0);
  assign pop      = o_valid & o_ready;
  assign o_data   = o_valid ? fifo_q[rd_ptr_q] : '0;
  assign o_last   = o_valid && (pop_cnt_q == n_q - CW'(1));
  assign last_pop = pop && (pop_cnt_q == n_q - CW'(1));

  assign seq_busy = (state_q != IDLE);

`ifdef PE_HOST_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt_q;
  logic          err_q;

  assign timeout_hit = (state_q == WAIT) && !pe_done && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign seq_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + TW'(1) : '0;
      if (cmd_fire)
        err_q <= 1'b0;
      else if (timeout_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign seq_err     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pe_start     = 1'b0;
    pe_clear_acc = 1'b0;
    seq_done     = 1'b0;
    case (state_q)
      IDLE:  if (cmd_fire) state_d = LOAD;
      LOAD:  if ((w_cnt_q == n_q) && (i_cnt_q == n_q)) state_d = START;
      START: begin
        pe_start     = 1'b1;
        pe_clear_acc = clear_q;
        state_d      = WAIT;
      end
      WAIT: begin
        if (pe_done)
          state_d = DRAIN;
        else if (timeout_hit)
          state_d = FIN;
      end
      DRAIN: if (last_pop) state_d = FIN;
      FIN: begin
        seq_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= CW'(BUF_DEPTH);
      clear_q     <= 1'b0;
      w_cnt_q     <= '0;
      i_cnt_q     <= '0;
      rd_cnt_q    <= '0;
      pop_cnt_q   <= '0;
      rd_vld_p0_q <= 1'b0;
      rd_vld_p1_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        n_q       <= n_cmd;
        clear_q   <= cmd_clear;
        w_cnt_q   <= '0;
        i_cnt_q   <= '0;
        rd_cnt_q  <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (w_fire)   w_cnt_q   <= w_cnt_q + CW'(1);
        if (i_fire)   i_cnt_q   <= i_cnt_q + CW'(1);
        if (rd_issue) rd_cnt_q  <= rd_cnt_q + CW'(1);
        if (pop)      pop_cnt_q <= pop_cnt_q + CW'(1);
      end
      // obuf read: issue -> p0 -> p1, data valid on the bus while p1 is set
      rd_vld_p0_q <= rd_issue;
      rd_vld_p1_q <= rd_vld_p0_q;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= obuf_rd_data;
  end

endmodule

// File: doc/pe_host_seq.md
PE_HOST_SEQ -- requirements
Module: pe_host_seq

Interface
REQ-001 Param SUBARRAY_ROWS, default 32, PE output rows.
REQ-002 Param SUBARRAY_COLS, default 8, PE input columns.
REQ-003 Params INPUT_WIDTH 8, WEIGHT_WIDTH 8, OUTPUT_WIDTH 32: element widths. WBW=ROWS*COLS*WEIGHT_WIDTH, IBW=COLS*INPUT_WIDTH, OBW=ROWS*OUTPUT_WIDTH, AW=$clog2(BUF_DEPTH).
REQ-004 Param BUF_DEPTH, default 4, entries per PE buffer; TIMEOUT_CYCLES, default 1024, watchdog limit.
REQ-005 clk in 1: single clock, rising edge. rst_n in 1: asynchronous active-low reset.
REQ-006 cmd_valid in 1, cmd_ready out 1, cmd_len in AW+1 (entry count N), cmd_clear in 1: job command handshake.
REQ-007 w_valid in 1, w_ready out 1, w_data in WBW: weight entry stream. i_valid in 1, i_ready out 1, i_data in IBW: input entry stream.
REQ-008 o_valid out 1, o_ready in 1, o_data out OBW, o_last out 1: result stream.
REQ-009 wbuf_wr_addr out AW, wbuf_wr_data out WBW, wbuf_wr_en out 1; ibuf_wr_addr out AW, ibuf_wr_data out IBW, ibuf_wr_en out 1: PE buffer write ports.
REQ-010 obuf_rd_addr out AW, obuf_rd_en out 1, obuf_rd_data in OBW: PE output-buffer read port, fixed 2-cycle read latency.
REQ-011 pe_start out 1, pe_clear_acc out 1, pe_busy in 1, pe_done in 1: PE control. seq_busy out 1, seq_done out 1, seq_err out 1: status.

Function
REQ-012 FSM states IDLE, LOAD, START, WAIT, DRAIN, FIN; cmd_ready=1 only in IDLE.
REQ-013 IDLE: cmd_valid&cmd_ready latches N and cmd_clear -> LOAD; N=0 or N>BUF_DEPTH latched as BUF_DEPTH.
REQ-014 LOAD: w and i streams independent; w_ready=1 while w_cnt<N; each w beat drives wbuf_wr_en=1, wbuf_wr_addr=w_cnt, wbuf_wr_data=w_data same cycle (zero-latency pass-through), w_cnt++; same for i stream with i_cnt.
REQ-015 LOAD -> START when w_cnt==N and i_cnt==N; beats outside LOAD never accepted (ready=0).
REQ-016 START: pe_start=1 and pe_clear_acc=latched clear for exactly one cycle -> WAIT.
REQ-017 WAIT: stay until pe_done=1 -> DRAIN; pe_done in any other state ignored.
REQ-018 DRAIN: issue obuf_rd_en=1, obuf_rd_addr=rd_cnt (0..N-1 ascending) only when inflight+fifo_count<4; capture obuf_rd_data exactly 2 cycles after each issue into 4-entry result FIFO; FIFO never overflows.
REQ-019 o_valid=FIFO non-empty; pop on o_valid&o_ready; o_data=FIFO head; o_last=1 on Nth result only; o_data/o_last stable while o_valid&!o_ready.
REQ-020 DRAIN -> FIN when N results popped; FIN: seq_done=1 one cycle -> IDLE.
REQ-021 seq_busy=1 in every state except IDLE; o_ready held low stalls drain indefinitely with no lost/duplicated entries.

Reset
REQ-022 rst_n low asynchronously forces IDLE, clears counters, FIFO, inflight tracking; all outputs 0 except cmd_ready=1.
REQ-023 Reset mid-job aborts job; no partial result emitted afterwards; data in flight from PE buffers discarded.

Configuration
REQ-024 Macro PE_HOST_SEQ_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without pe_done -> FIN with seq_err=1 (held until next cmd accepted), drain skipped, seq_done pulses.
REQ-025 Macro undefined: no watchdog logic, WAIT indefinite, seq_err tied 0.

Verification
REQ-026 N=4, clear=1, 4 w and 4 i beats, pe_done 10 cycles after pe_start -> writes addr 0..3, one pe_start with pe_clear_acc=1, 4 results addr 0..3 in order, o_last on 4th, seq_done once.
REQ-027 cmd_len=0 -> behaves as N=4; cmd_len=7 -> N=4.
REQ-028 N=3, all 3 i beats before any w beat -> START only after 3rd w beat; no 4th write.
REQ-029 N=4, o_ready low 20 cycles during DRAIN -> at most 4 reads issued, data held stable, no loss.
REQ-030 rst_n low for 1 cycle in WAIT -> outputs reset immediately, cmd_ready=1 next cycle, no o_valid.
REQ-031 With PE_HOST_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, pe_done never asserted -> seq_err=1 and seq_done at cycle 16 of WAIT, no o_valid.
